// File: rtl/step_debug_ctrl.sv
// -----------------------------------------------------------------------------
// step_debug_ctrl
//   Single-step debug front end for a hand-clocked processor. A bouncing,
//   active-low push button is synchronised and debounced into a one-clock
//   StepPulse (used as the processor clock enable), presses are counted, and
//   one of NCH channel words is selected for the hex displays.
//   Display selection can be manual (Sel), auto-scan (rotating channels with a
//   dwell timer, also advanced by each step), or freeze (hold, but re-snapshot
//   the shown channel after each step).
//
// Ports
//   CLOCK_50   in   1       system clock, rising edge
//   Reset      in   1       synchronous, active-high
//   KeyN       in   1       raw step button, active-low, asynchronous
//   Mode       in   2       00 manual, 01 auto-scan, 10 freeze, 11 manual
//   Sel        in   SW      manual channel select
//   ChIn       in   NCH*W   packed channels, channel k at [k*W +: W]
//   StepPulse  out  1       one-clock pulse per debounced press
//   StepCount  out  16      debounced presses since reset (wraps)
//   DispCh     out  SW      channel being shown
//   DispData   out  W       registered display word
// -----------------------------------------------------------------------------
module step_debug_ctrl #(
  parameter  int NCH         = 8,
  parameter  int W           = 16,
  parameter  int DB_CYCLES   = 500000,
  parameter  int SCAN_CYCLES = 50000000,
  localparam int SW          = $clog2(NCH)
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic               KeyN,
  input  logic [1:0]         Mode,
  input  logic [SW-1:0]      Sel,
  input  logic [NCH*W-1:0]   ChIn,
  output logic               StepPulse,
  output logic [15:0]        StepCount,
  output logic [SW-1:0]      DispCh,
  output logic [W-1:0]       DispData
);

  localparam int DBW   = $clog2(DB_CYCLES + 1);
  localparam int SCW   = $clog2(SCAN_CYCLES + 1);
  localparam int NSLOT = 1 << SW;

  typedef enum logic [1:0] {
    M_MANUAL  = 2'b00,
    M_AUTO    = 2'b01,
    M_FREEZE  = 2'b10,
    M_MANUAL2 = 2'b11
  } mode_e;

  // ---------------------------------------------------------------------------
  // Key synchroniser and debounce
  // ---------------------------------------------------------------------------
  logic           r_sync1, r_sync2;
  logic           r_stable;
  logic [DBW-1:0] r_db_cnt;
  logic           r_pulse;
  logic [15:0]    r_step_cnt;

  logic w_key, w_differ, w_db_done;

  assign w_key     = r_sync2;
  assign w_differ  = (w_key != r_stable);
  // The counter would reach DB_CYCLES on this edge: accept the new level.
  assign w_db_done = w_differ && (r_db_cnt == DBW'(DB_CYCLES - 1));

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_stable   <= 1'b1;
      r_db_cnt   <= '0;
      r_pulse    <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_sync1 <= KeyN;
      r_sync2 <= r_sync1;
      if (!w_differ) begin
        r_db_cnt <= '0;
      end else if (w_db_done) begin
        r_db_cnt <= '0;
        r_stable <= w_key;
      end else begin
        r_db_cnt <= r_db_cnt + DBW'(1);
      end
      // Pulse only on the press transition (Stable 1->0), never on release.
      r_pulse <= w_db_done && !w_key;
      if (r_pulse)
        r_step_cnt <= r_step_cnt + 16'd1;
    end
  end

  assign StepPulse = r_pulse;
  assign StepCount = r_step_cnt;

  // ---------------------------------------------------------------------------
  // Channel table, padded with zero words up to a power of two so any Sel /
  // DispCh value indexes safely and out-of-range channels read as 0.
  // ---------------------------------------------------------------------------
  logic [W-1:0] w_chan [NSLOT];

  for (genvar k = 0; k < NSLOT; k++) begin : g_ch
    if (k < NCH) begin : g_real
      assign w_chan[k] = ChIn[k*W +: W];
    end else begin : g_pad
      assign w_chan[k] = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Display selection
  // ---------------------------------------------------------------------------
  logic [SW-1:0]  r_disp_ch;
  logic [W-1:0]   r_disp_data;
  logic [SCW-1:0] r_dwell;

  mode_e          w_mode;
  logic [SW-1:0]  w_base, w_adv;
  logic           w_dwell_done;
  logic [SW-1:0]  w_nxt_ch;
  logic [W-1:0]   w_nxt_data;
  logic [SCW-1:0] w_nxt_dwell;

  assign w_mode       = mode_e'(Mode);
  // Scanning resumes from the shown channel, clamped into the real range.
  assign w_base       = (32'(r_disp_ch) >= NCH) ? '0 : r_disp_ch;
  assign w_adv        = (32'(w_base) == NCH - 1) ? '0 : w_base + SW'(1);
  assign w_dwell_done = (r_dwell == SCW'(SCAN_CYCLES - 1));

  always_comb begin
    w_nxt_ch    = r_disp_ch;
    w_nxt_data  = r_disp_data;
    w_nxt_dwell = '0;
    case (w_mode)
      M_AUTO: begin
        w_nxt_data = w_chan[r_disp_ch];
        // A step and a dwell expiry in the same cycle still advance only once.
        if (r_pulse || w_dwell_done) begin
          w_nxt_ch = w_adv;
        end else begin
          w_nxt_ch    = w_base;
          w_nxt_dwell = r_dwell + SCW'(1);
        end
      end
      M_FREEZE: begin
        // Post-step snapshot of whatever channel is frozen on screen.
        if (r_pulse)
          w_nxt_data = w_chan[r_disp_ch];
      end
      default: begin
        w_nxt_ch   = Sel;
        w_nxt_data = w_chan[Sel];
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_disp_ch   <= '0;
      r_disp_data <= '0;
      r_dwell     <= '0;
    end else begin
      r_disp_ch   <= w_nxt_ch;
      r_disp_data <= w_nxt_data;
      r_dwell     <= w_nxt_dwell;
    end
  end

  assign DispCh   = r_disp_ch;
  assign DispData = r_disp_data;

endmodule

// File: tb/tb_step_debug_ctrl.sv
// -----------------------------------------------------------------------------
// tb_step_debug_ctrl
//   Directed bench for step_debug_ctrl. Two instances:
//     u_a  NCH=5, DB_CYCLES=4, SCAN_CYCLES=3  debounce, manual select, wrap,
//                                               reset during debounce
//     u_b  NCH=4, DB_CYCLES=2, SCAN_CYCLES=3  auto-scan and freeze
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_step_debug_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // instance A
  logic        rst_a, key_a;
  logic [1:0]  mode_a;
  logic [2:0]  sel_a;
  logic [79:0] chin_a;
  logic        sp_a;
  logic [15:0] sc_a;
  logic [2:0]  ch_a;
  logic [15:0] dd_a;

  // instance B
  logic        rst_b, key_b;
  logic [1:0]  mode_b;
  logic [1:0]  sel_b;
  logic [63:0] chin_b;
  logic        sp_b;
  logic [15:0] sc_b;
  logic [1:0]  ch_b;
  logic [15:0] dd_b;

  step_debug_ctrl #(.NCH(5), .W(16), .DB_CYCLES(4), .SCAN_CYCLES(3)) u_a (
    .CLOCK_50(clk), .Reset(rst_a), .KeyN(key_a), .Mode(mode_a), .Sel(sel_a),
    .ChIn(chin_a), .StepPulse(sp_a), .StepCount(sc_a), .DispCh(ch_a),
    .DispData(dd_a)
  );

  step_debug_ctrl #(.NCH(4), .W(16), .DB_CYCLES(2), .SCAN_CYCLES(3)) u_b (
    .CLOCK_50(clk), .Reset(rst_b), .KeyN(key_b), .Mode(mode_b), .Sel(sel_b),
    .ChIn(chin_b), .StepPulse(sp_b), .StepCount(sc_b), .DispCh(ch_b),
    .DispData(dd_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // auto-scan expectations after each of 9 edges, starting from channel 3
  int scan_ch   [9] = '{3, 3, 0, 0, 0, 1, 1, 1, 2};
  int scan_data [9] = '{'h00D3, 'h00D3, 'h00D3, 'h000A, 'h000A, 'h000A,
                        'h1234, 'h1234, 'h1234};

  initial begin
    int pulses;

    rst_a  = 1'b1; key_a = 1'b1; mode_a = 2'b00; sel_a = 3'd2;
    chin_a = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
    rst_b  = 1'b1; key_b = 1'b1; mode_b = 2'b00; sel_b = 2'd3;
    chin_b = {16'h00D3, 16'h00C2, 16'h1234, 16'h000A};
    repeat (3) tick();

    // reset state (Sel=2 must not leak through while in reset)
    check("rst_pulse", 32'(sp_a), 32'h0);
    check("rst_count", 32'(sc_a), 32'h0);
    check("rst_dispch", 32'(ch_a), 32'h0);
    check("rst_dispdata", 32'(dd_a), 32'h0);

    // manual select: Sel=2 -> ChIn[47:32] one edge later
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    check("man_ch2", 32'(ch_a), 32'd2);
    check("man_data2", 32'(dd_a), 32'h3333);
    sel_a = 3'd6;
    #2;
    check("man_latency", 32'(dd_a), 32'h3333);
    tick();
    check("man_ch6", 32'(ch_a), 32'd6);
    check("man_data6", 32'(dd_a), 32'h0);

    // debounce: low 3, high 2, then low 20; pulse sampled 5 edges after the
    // first edge that sees the final low (i.e. high in cycle t+6)
    key_a = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); check("bounce_lo", 32'(sp_a), 32'h0); end
    key_a = 1'b1;
    for (int k = 0; k < 2; k++) begin tick(); check("bounce_hi", 32'(sp_a), 32'h0); end
    key_a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("db_pulse_k%0d", k), 32'(sp_a), (k == 5) ? 32'h1 : 32'h0);
    end
    check("db_count", 32'(sc_a), 32'd1);
    key_a = 1'b1;
    for (int k = 0; k < 12; k++) begin tick(); check("release_nopulse", 32'(sp_a), 32'h0); end
    check("release_count", 32'(sc_a), 32'd1);

    // wrap: preload stands in for 65535 earlier presses
    force u_a.r_step_cnt = 16'hFFFF;
    tick();
    release u_a.r_step_cnt;
    tick();
    check("preload", 32'(sc_a), 32'hFFFF);
    key_a = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin tick(); if (sp_a) pulses++; end
    check("wrap_pulses", 32'(pulses), 32'd1);
    check("wrap_count", 32'(sc_a), 32'h0);
    key_a = 1'b1;
    repeat (12) tick();

    // reset mid-debounce with the key held low
    key_a = 1'b0;
    repeat (3) tick();
    rst_a = 1'b1;
    for (int k = 0; k < 4; k++) begin tick(); check("rst_mid_pulse", 32'(sp_a), 32'h0); end
    check("rst_mid_dispch", 32'(ch_a), 32'h0);
    check("rst_mid_count", 32'(sc_a), 32'h0);
    rst_a = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("rst_rel_pulse_k%0d", k), 32'(sp_a), (k == 5) ? 32'h1 : 32'h0);
    end
    check("rst_rel_count", 32'(sc_a), 32'd1);
    key_a = 1'b1;

    // auto-scan from DispCh=3 (B has been in manual with Sel=3)
    check("scan_start_ch", 32'(ch_b), 32'd3);
    check("scan_start_data", 32'(dd_b), 32'h00D3);
    mode_b = 2'b01;
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("scan_ch_e%0d", k + 1), 32'(ch_b), 32'(scan_ch[k]));
      check($sformatf("scan_data_e%0d", k + 1), 32'(dd_b), 32'(scan_data[k]));
    end

    // freeze: show channel 1 (0x1234), change it to 0xBEEF, then step
    mode_b = 2'b00; sel_b = 2'd1;
    tick();
    check("frz_setup", 32'(dd_b), 32'h1234);
    mode_b = 2'b10;
    chin_b[31:16] = 16'hBEEF;
    sel_b = 2'd3;
    repeat (2) tick();
    check("frz_hold_data", 32'(dd_b), 32'h1234);
    check("frz_hold_ch", 32'(ch_b), 32'd1);
    key_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("frz_wait_pulse", 32'(sp_b), 32'h0);
      check("frz_wait_data", 32'(dd_b), 32'h1234);
    end
    tick();
    check("frz_pulse", 32'(sp_b), 32'h1);
    check("frz_pre_snap", 32'(dd_b), 32'h1234);
    tick();
    check("frz_post_pulse", 32'(sp_b), 32'h0);
    check("frz_snap", 32'(dd_b), 32'hBEEF);
    check("frz_ch", 32'(ch_b), 32'd1);
    check("frz_count", 32'(sc_b), 32'd1);
    key_b = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/step_debug_ctrl.md
STEP_DEBUG_CTRL -- requirements
Module: step_debug_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 8, meaning number of display channels (2..16).
REQ-002 SHALL have parameter W, default 16, meaning width of each channel word.
REQ-003 SHALL have parameter DB_CYCLES, default 500000, meaning debounce stability count in clocks (>=2).
REQ-004 SHALL have parameter SCAN_CYCLES, default 50000000, meaning auto-scan dwell per channel in clocks (>=2).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-007 SHALL have port Reset  input  1  synchronous active-high reset.
REQ-008 SHALL have port KeyN  input  1  raw asynchronous step button, active-low, bouncing.
REQ-009 SHALL have port Mode  input  2  00 manual, 01 auto-scan, 10 freeze, 11 treated as manual.
REQ-010 SHALL have port Sel  input  SW=clog2(NCH)  manual channel select.
REQ-011 SHALL have port ChIn  input  NCH*W  packed channels; channel k at bits [k*W+W-1 : k*W].
REQ-012 SHALL have port StepPulse  output  1  one-clock pulse per debounced press; drives processor clock enable.
REQ-013 SHALL have port StepCount  output  16  number of debounced presses since reset.
REQ-014 SHALL have port DispCh  output  SW  channel currently shown.
REQ-015 SHALL have port DispData  output  W  registered word for hex displays.

Function
REQ-016 SHALL pass KeyN through a 2-flop synchroniser before any other use.
REQ-017 SHALL keep a debounced level Stable; a counter increments each cycle the synchronised key differs from Stable and clears each cycle it matches.
REQ-018 SHALL, when the counter would reach DB_CYCLES, load Stable with the synchronised value and clear the counter in the same edge.
REQ-019 SHALL assert StepPulse for exactly one cycle in the cycle Stable goes 1->0; no pulse on release (0->1).
REQ-020 SHALL, for KeyN falling before edge t and held low, assert StepPulse in cycle t+2+DB_CYCLES; bounces shorter than DB_CYCLES produce no pulse.
REQ-021 SHALL increment StepCount on each StepPulse, wrapping 16'hFFFF -> 0.
REQ-022 SHALL, in manual mode, register DispCh <= Sel and DispData <= channel Sel each cycle (one-cycle latency).
REQ-023 SHALL, for Sel >= NCH in manual mode, set DispCh <= Sel and DispData <= 0.
REQ-024 SHALL, in auto-scan mode, count dwell cycles; when the count reaches SCAN_CYCLES-1, clear the count and advance DispCh by 1, wrapping NCH-1 -> 0; DispData tracks channel DispCh with one-cycle latency.
REQ-025 SHALL, on entering auto-scan, start from current DispCh (clamped to 0 if >= NCH) with dwell count 0.
REQ-026 SHALL, in auto-scan, advance DispCh immediately and clear the dwell count on StepPulse; a StepPulse coinciding with dwell expiry advances by one channel only.
REQ-027 SHALL, in freeze mode, hold DispCh and DispData unchanged, except that each StepPulse recaptures DispData from channel DispCh on the same edge (post-step snapshot).
REQ-028 SHALL clear the dwell count whenever Mode is not auto-scan.
REQ-029 SHALL apply Mode changes on the first edge the new value is sampled; no intermediate state.
REQ-030 SHALL keep debounce and StepCount operating identically in all modes.

Reset
REQ-031 SHALL, while Reset is high at an edge, set synchroniser flops and Stable to 1, debounce and dwell counters to 0, StepPulse 0, StepCount 0, DispCh 0, DispData 0.
REQ-032 SHALL give Reset priority over every other event in the same cycle, including a pending StepPulse.
REQ-033 SHALL, if KeyN is held low through reset release, issue exactly one StepPulse DB_CYCLES+2 cycles after the first non-reset edge.

Verification
REQ-034 Bench SHALL cover: DB_CYCLES=4, KeyN low 3 cycles, high 2, then low 20 -> one StepPulse at cycle t+6 from the final fall, StepCount=1.
REQ-035 Bench SHALL cover: NCH=5, manual, Sel=2 then Sel=6 -> DispData = ChIn[47:32] one cycle later, then DispData=0 with DispCh=6.
REQ-036 Bench SHALL cover: NCH=4, SCAN_CYCLES=3, auto-scan from DispCh=3 -> DispCh sequence 3,0,1,2 changing every 3 cycles.
REQ-037 Bench SHALL cover: freeze with channel 1=16'h1234, ChIn changed to 16'hBEEF, then press -> DispData stays 16'h1234 until StepPulse, then 16'hBEEF.
REQ-038 Bench SHALL cover: StepCount preloaded to 16'hFFFF by 65535 presses, one more press -> StepCount=0.
REQ-039 Bench SHALL cover: Reset asserted mid-debounce with KeyN low -> no pulse during reset, single pulse DB_CYCLES+2 cycles after release, StepCount=1.
